// File: rtl/riscv_defs_pkg.sv
// Shared types and widths for the RISC-V memory arbiter slice.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which port owns the bus transaction
//   arb_req_t   : request latched at acceptance and replayed on the bus
package riscv_defs_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned STRB_W      = 4;
  localparam int unsigned ARB_TIMER_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_FETCH = 1'b0,
    ARB_OWNER_DATA  = 1'b1
  } arb_owner_t;

  typedef struct packed {
    arb_owner_t        owner;
    logic [XLEN-1:0]   addr;
    logic [STRB_W-1:0] wr;
    logic [XLEN-1:0]   data;
  } arb_req_t;

endpackage

// File: rtl/riscv_arb_timer.sv
// Bus watchdog: counts while enabled, cleared when not, flags the last allowed cycle.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : force count to zero
//   en_i         : count this cycle
//   expire_c     : combinational, high on the LIMIT-th enabled cycle (never when LIMIT == 0)
module riscv_arb_timer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  localparam logic             ENABLED = (LIMIT != 0);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q;

  // Saturating up-counter so a disabled watchdog never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign expire_c = ENABLED & en_i & (cnt_q == LAST);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-outstanding 32-bit memory bus between the fetch port and the
// data/LSU port; steers responses back to the owner and aborts hung transactions.
//   icache_*  : fetch request/response port
//   mem_d_*   : data request/response port
//   bus_*     : external bus; request held until bus_accept_i, response on bus_ack_i
// Config: define RISCV_ARB_RR_EN for round-robin arbitration; default is fixed
// priority with the data port always winning.
module riscv_mem_arbiter
  import riscv_defs_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              icache_rd_i,
  input  logic [XLEN-1:0]   icache_pc_i,
  output logic              icache_accept_o,
  output logic              icache_valid_o,
  output logic              icache_error_o,
  output logic [XLEN-1:0]   icache_inst_o,
  output logic [XLEN-1:0]   icache_inst_pc_o,
  input  logic              mem_d_rd_i,
  input  logic [STRB_W-1:0] mem_d_wr_i,
  input  logic [XLEN-1:0]   mem_d_addr_i,
  input  logic [XLEN-1:0]   mem_d_data_wr_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [XLEN-1:0]   mem_d_data_rd_o,
  output logic              bus_rd_o,
  output logic [STRB_W-1:0] bus_wr_o,
  output logic [XLEN-1:0]   bus_addr_o,
  output logic [XLEN-1:0]   bus_data_wr_o,
  input  logic              bus_accept_i,
  input  logic              bus_ack_i,
  input  logic              bus_error_i,
  input  logic [XLEN-1:0]   bus_data_rd_i
);

  arb_state_t      state_q, state_d;
  arb_req_t        req_q;
  logic            data_req_c, data_wins_c, fetch_wins_c;
  logic            idle_c, fetch_grant_c, data_grant_c;
  logic            resp_fire_c, resp_err_c;
  logic [XLEN-1:0] resp_data_c;
  logic            timer_clr_c, timer_en_c, timer_expire_c;

  assign data_req_c = mem_d_rd_i | (|mem_d_wr_i);

`ifdef RISCV_ARB_RR_EN
  arb_owner_t last_grant_q;

  // When both ports request, the one not granted last time wins.
  assign data_wins_c  = data_req_c & (last_grant_q == ARB_OWNER_FETCH);
  assign fetch_wins_c = icache_rd_i & ((last_grant_q == ARB_OWNER_DATA) | !data_req_c);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= ARB_OWNER_DATA;
    end else if (fetch_grant_c) begin
      last_grant_q <= ARB_OWNER_FETCH;
    end else if (data_grant_c) begin
      last_grant_q <= ARB_OWNER_DATA;
    end
  end
`else
  assign data_wins_c  = data_req_c;
  assign fetch_wins_c = !data_req_c;
`endif

  // Accepts look only at state and the competing port, never at icache_rd_i itself.
  assign idle_c          = (state_q == ARB_IDLE) & !rst_i;
  assign icache_accept_o = idle_c & !data_wins_c;
  assign mem_d_accept_o  = idle_c & !fetch_wins_c;
  assign fetch_grant_c   = icache_accept_o & icache_rd_i;
  assign data_grant_c    = mem_d_accept_o & data_req_c;

  riscv_arb_timer #(
    .WIDTH(ARB_TIMER_W),
    .LIMIT(BUS_TIMEOUT)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (timer_clr_c),
    .en_i    (timer_en_c),
    .expire_c(timer_expire_c)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next state and response selection; an ack in the timeout cycle takes precedence.
  always_comb begin
    state_d     = state_q;
    resp_fire_c = 1'b0;
    resp_err_c  = 1'b0;
    resp_data_c = '0;
    timer_clr_c = 1'b1;
    timer_en_c  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (fetch_grant_c || data_grant_c) state_d = ARB_REQ;
      end
      ARB_REQ: begin
        if (bus_accept_i) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        timer_clr_c = 1'b0;
        timer_en_c  = 1'b1;
        if (bus_ack_i) begin
          resp_fire_c = 1'b1;
          resp_err_c  = bus_error_i;
          resp_data_c = bus_data_rd_i;
          state_d     = ARB_IDLE;
        end else if (timer_expire_c) begin
          resp_fire_c = 1'b1;
          resp_err_c  = 1'b1;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request latch and bus request strobes; a read+write request goes out as a write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q    <= '0;
      bus_rd_o <= 1'b0;
      bus_wr_o <= '0;
    end else if (fetch_grant_c) begin
      req_q.owner <= ARB_OWNER_FETCH;
      req_q.addr  <= icache_pc_i;
      req_q.wr    <= '0;
      req_q.data  <= '0;
      bus_rd_o    <= 1'b1;
      bus_wr_o    <= '0;
    end else if (data_grant_c) begin
      req_q.owner <= ARB_OWNER_DATA;
      req_q.addr  <= mem_d_addr_i;
      req_q.wr    <= mem_d_wr_i;
      req_q.data  <= mem_d_data_wr_i;
      bus_rd_o    <= ~(|mem_d_wr_i);
      bus_wr_o    <= mem_d_wr_i;
    end else if ((state_q == ARB_REQ) && bus_accept_i) begin
      bus_rd_o <= 1'b0;
      bus_wr_o <= '0;
    end
  end

  assign bus_addr_o    = req_q.addr;
  assign bus_data_wr_o = req_q.data;

  // Response steering: one-cycle pulse to the owner, payload held until the next response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      icache_valid_o   <= 1'b0;
      icache_error_o   <= 1'b0;
      icache_inst_o    <= '0;
      icache_inst_pc_o <= '0;
      mem_d_ack_o      <= 1'b0;
      mem_d_error_o    <= 1'b0;
      mem_d_data_rd_o  <= '0;
    end else begin
      icache_valid_o <= 1'b0;
      icache_error_o <= 1'b0;
      mem_d_ack_o    <= 1'b0;
      mem_d_error_o  <= 1'b0;
      if (resp_fire_c) begin
        if (req_q.owner == ARB_OWNER_FETCH) begin
          icache_valid_o   <= 1'b1;
          icache_error_o   <= resp_err_c;
          icache_inst_o    <= resp_data_c;
          icache_inst_pc_o <= req_q.addr;
        end else begin
          mem_d_ack_o     <= 1'b1;
          mem_d_error_o   <= resp_err_c;
          mem_d_data_rd_o <= resp_data_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: arbitration table, directed corner
// sequences, then a randomized run against a transaction-level reference model.
module tb_riscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        icache_rd_i;
  logic [31:0] icache_pc_i;
  logic        icache_accept_o, icache_valid_o, icache_error_o;
  logic [31:0] icache_inst_o, icache_inst_pc_o;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0] mem_d_data_rd_o;
  logic        bus_rd_o;
  logic [3:0]  bus_wr_o;
  logic [31:0] bus_addr_o, bus_data_wr_o;
  logic        bus_accept_i, bus_ack_i, bus_error_i;
  logic [31:0] bus_data_rd_i;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_mem_arbiter #(.BUS_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .icache_rd_i(icache_rd_i), .icache_pc_i(icache_pc_i),
    .icache_accept_o(icache_accept_o), .icache_valid_o(icache_valid_o),
    .icache_error_o(icache_error_o), .icache_inst_o(icache_inst_o),
    .icache_inst_pc_o(icache_inst_pc_o),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_addr_i(mem_d_addr_i),
    .mem_d_data_wr_i(mem_d_data_wr_i), .mem_d_accept_o(mem_d_accept_o),
    .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
    .mem_d_data_rd_o(mem_d_data_rd_o),
    .bus_rd_o(bus_rd_o), .bus_wr_o(bus_wr_o), .bus_addr_o(bus_addr_o),
    .bus_data_wr_o(bus_data_wr_o), .bus_accept_i(bus_accept_i), .bus_ack_i(bus_ack_i),
    .bus_error_i(bus_error_i), .bus_data_rd_i(bus_data_rd_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       irq;
    logic       drd;
    logic [3:0] dwr;
    logic       exp_iacc;
    logic       exp_dacc;
  } arb_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    icache_rd_i = 0; icache_pc_i = '0;
    mem_d_rd_i = 0; mem_d_wr_i = '0; mem_d_addr_i = '0; mem_d_data_wr_i = '0;
    bus_accept_i = 0; bus_ack_i = 0; bus_error_i = 0; bus_data_rd_i = '0;
  endtask

  // Called in the first REQ cycle; returns in the response-pulse cycle.
  task automatic run_txn(input bit is_data, input logic [31:0] addr, input logic [3:0] wr,
                         input logic [31:0] wdata, input int acc_dly, input int ack_dly,
                         input bit err, input logic [31:0] rdata, input string nm);
    for (int i = 0; i <= acc_dly; i++) begin
      chk({nm, "_bus_rd"}, bus_rd_o, (wr == 4'h0));
      chk({nm, "_bus_wr"}, bus_wr_o, wr);
      chk({nm, "_bus_addr"}, bus_addr_o, addr);
      if (wr != 4'h0) chk({nm, "_bus_wdata"}, bus_data_wr_o, wdata);
      bus_accept_i = (i == acc_dly);
      #1;
      chk({nm, "_no_accept"}, {icache_accept_o, mem_d_accept_o}, 0);
      tick();
    end
    bus_accept_i = 0;
    chk({nm, "_bus_drop"}, {bus_rd_o, bus_wr_o}, 0);
    for (int i = 0; i < ack_dly; i++) begin
      chk({nm, "_early_resp"}, {icache_valid_o, mem_d_ack_o}, 0);
      tick();
    end
    bus_ack_i = 1; bus_error_i = err; bus_data_rd_i = rdata;
    tick();
    bus_ack_i = 0; bus_error_i = 0; bus_data_rd_i = '0;
    if (is_data) begin
      chk({nm, "_dack"}, mem_d_ack_o, 1);
      chk({nm, "_derr"}, mem_d_error_o, err);
      if (wr == 4'h0 || err) chk({nm, "_ddata"}, mem_d_data_rd_o, rdata);
      chk({nm, "_ivalid_quiet"}, icache_valid_o, 0);
    end else begin
      chk({nm, "_ivalid"}, icache_valid_o, 1);
      chk({nm, "_ierr"}, icache_error_o, err);
      chk({nm, "_inst"}, icache_inst_o, rdata);
      chk({nm, "_ipc"}, icache_inst_pc_o, addr);
      chk({nm, "_dack_quiet"}, mem_d_ack_o, 0);
    end
  endtask

  initial begin
    arb_vec_t vecs[6];
    // reference model state for the random phase
    bit          m_busy, resp_due, m_last_data, f_pend, d_pend, d_rd, r_owner, r_err, r_chk;
    bit          e_owner;
    int          m_phase, wait_left, g;
    logic [31:0] f_pc, d_addr, d_wdata, e_addr, e_wdata, r_data, r_pc, tmp;
    logic [3:0]  d_wr, e_wr;

    idle_inputs();
    rst_i = 1;
    repeat (2) tick();
    rst_i = 0;

    // reset state
    chk("rst_bus_rd", bus_rd_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_ivalid", icache_valid_o, 0);
    chk("rst_dack", mem_d_ack_o, 0);
    #1;
    chk("rst_iacc", icache_accept_o, 1);
    tick();

    // combinational arbitration in IDLE, last grant = DATA after reset
`ifdef RISCV_ARB_RR_EN
    vecs[0] = '{0, 0, 4'h0, 1, 1};
    vecs[1] = '{1, 0, 4'h0, 1, 0};
    vecs[2] = '{0, 1, 4'h0, 1, 1};
    vecs[3] = '{0, 0, 4'h3, 1, 1};
    vecs[4] = '{1, 1, 4'h0, 1, 0};
    vecs[5] = '{1, 1, 4'hC, 1, 0};
`else
    vecs[0] = '{0, 0, 4'h0, 1, 0};
    vecs[1] = '{1, 0, 4'h0, 1, 0};
    vecs[2] = '{0, 1, 4'h0, 0, 1};
    vecs[3] = '{0, 0, 4'h3, 0, 1};
    vecs[4] = '{1, 1, 4'h0, 0, 1};
    vecs[5] = '{1, 1, 4'hC, 0, 1};
`endif
    foreach (vecs[i]) begin
      icache_rd_i = vecs[i].irq; mem_d_rd_i = vecs[i].drd; mem_d_wr_i = vecs[i].dwr;
      #1;
      chk($sformatf("tbl%0d_iacc", i), icache_accept_o, vecs[i].exp_iacc);
      chk($sformatf("tbl%0d_dacc", i), mem_d_accept_o, vecs[i].exp_dacc);
      idle_inputs();
      tick();
    end

    // both request in the same cycle
    mem_d_wr_i = 4'hF; mem_d_addr_i = 32'h0000_1000; mem_d_data_wr_i = 32'hDEAD_BEEF;
    icache_rd_i = 1; icache_pc_i = 32'h8000_0004;
    #1;
`ifdef RISCV_ARB_RR_EN
    chk("t2_iacc", icache_accept_o, 1);
    chk("t2_dacc", mem_d_accept_o, 0);
    tick(); icache_rd_i = 0;
    run_txn(0, 32'h8000_0004, 4'h0, 0, 0, 1, 0, 32'h0010_0093, "t2a");
    #1; chk("t2_dacc_after", mem_d_accept_o, 1);
    tick(); mem_d_wr_i = 0;
    run_txn(1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0, "t2b");
`else
    chk("t2_iacc", icache_accept_o, 0);
    chk("t2_dacc", mem_d_accept_o, 1);
    tick(); mem_d_wr_i = 0;
    run_txn(1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 0, 1, 0, 0, "t2a");
    #1; chk("t2_iacc_after", icache_accept_o, 1);
    tick(); icache_rd_i = 0;
    run_txn(0, 32'h8000_0004, 4'h0, 0, 0, 0, 0, 32'h0010_0093, "t2b");
`endif
    tick();

    // fetch only, minimum latency
    icache_rd_i = 1; icache_pc_i = 32'h8000_0000;
    #1; chk("t1_iacc", icache_accept_o, 1);
    tick(); icache_rd_i = 0;
    run_txn(0, 32'h8000_0000, 4'h0, 0, 0, 0, 0, 32'h0000_0013, "t1");
    tick();
    chk("t1_pulse_end", icache_valid_o, 0);
    chk("t1_inst_hold", icache_inst_o, 32'h0000_0013);

    // data read with bus error
    mem_d_rd_i = 1; mem_d_addr_i = 32'h0000_3000;
    #1; chk("t3_dacc", mem_d_accept_o, 1);
    tick(); mem_d_rd_i = 0;
    run_txn(1, 32'h0000_3000, 4'h0, 0, 1, 2, 1, 32'h0BAD_F00D, "t3");
    tick();

    // timeout after 8 WAIT cycles, then stray acks ignored
    mem_d_rd_i = 1; mem_d_addr_i = 32'h0000_4000;
    #1; chk("t4_dacc", mem_d_accept_o, 1);
    tick(); mem_d_rd_i = 0;
    chk("t4_bus_rd", bus_rd_o, 1);
    bus_accept_i = 1;
    tick(); bus_accept_i = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_no_early_resp", mem_d_ack_o, 0);
      tick();
    end
    chk("t4_dack", mem_d_ack_o, 1);
    chk("t4_derr", mem_d_error_o, 1);
    chk("t4_ddata", mem_d_data_rd_o, 0);
    chk("t4_ivalid_quiet", icache_valid_o, 0);
    bus_ack_i = 1; bus_data_rd_i = 32'h5555_5555;
    tick(); tick();
    bus_ack_i = 0; bus_data_rd_i = '0;
    chk("t4_stray", {icache_valid_o, mem_d_ack_o}, 0);
    tick();
    chk("t4_stray2", {icache_valid_o, mem_d_ack_o}, 0);

    // bus stalls accept for 5 cycles while the data port also waits
    icache_rd_i = 1; icache_pc_i = 32'h8000_0100;
    #1; chk("t6_iacc", icache_accept_o, 1);
    tick(); icache_rd_i = 0;
    mem_d_rd_i = 1; mem_d_addr_i = 32'h0000_5000;
    run_txn(0, 32'h8000_0100, 4'h0, 0, 5, 0, 0, 32'h1234_5678, "t6");
    #1; chk("t6_dacc", mem_d_accept_o, 1);
    tick(); mem_d_rd_i = 0;
    run_txn(1, 32'h0000_5000, 4'h0, 0, 0, 0, 0, 32'hCAFE_F00D, "t6b");
    tick();

    // asynchronous reset during WAIT
    icache_rd_i = 1; icache_pc_i = 32'h8000_0200;
    #1; tick(); icache_rd_i = 0;
    bus_accept_i = 1;
    tick(); bus_accept_i = 0;
    chk("t5_pre_addr", bus_addr_o, 32'h8000_0200);
    #1; rst_i = 1; #1;
    chk("t5_addr", bus_addr_o, 0);
    chk("t5_rdwr", {bus_rd_o, bus_wr_o}, 0);
    chk("t5_inst", icache_inst_o, 0);
    chk("t5_ddata", mem_d_data_rd_o, 0);
    chk("t5_acc", {icache_accept_o, mem_d_accept_o}, 0);
    tick();
    bus_ack_i = 1;
    tick();
    rst_i = 0; bus_ack_i = 0;
    tick();
    chk("t5_no_resp", {icache_valid_o, mem_d_ack_o}, 0);
    mem_d_rd_i = 1; mem_d_wr_i = 4'h1; mem_d_addr_i = 32'h0000_6000; mem_d_data_wr_i = 32'h0000_00A5;
    #1; chk("t5_dacc", mem_d_accept_o, 1);
    tick(); mem_d_rd_i = 0; mem_d_wr_i = 0;
    run_txn(1, 32'h0000_6000, 4'h1, 32'h0000_00A5, 1, 1, 0, 0, "t5");

    // randomized traffic against a transaction-level model
    idle_inputs();
    rst_i = 1; tick(); rst_i = 0;
    m_busy = 0; resp_due = 0; m_last_data = 1; f_pend = 0; d_pend = 0; m_phase = 0;
    wait_left = 0; e_owner = 0; e_addr = '0; e_wr = '0; e_wdata = '0;
    r_owner = 0; r_err = 0; r_chk = 0; r_data = '0; r_pc = '0;
    f_pc = '0; d_addr = '0; d_wdata = '0; d_wr = '0; d_rd = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      chk("rnd_ivalid", icache_valid_o, resp_due && !r_owner);
      chk("rnd_dack", mem_d_ack_o, resp_due && r_owner);
      if (resp_due) begin
        if (r_owner) begin
          chk("rnd_derr", mem_d_error_o, r_err);
          if (r_chk) chk("rnd_ddata", mem_d_data_rd_o, r_data);
        end else begin
          chk("rnd_ierr", icache_error_o, r_err);
          chk("rnd_inst", icache_inst_o, r_data);
          chk("rnd_ipc", icache_inst_pc_o, r_pc);
        end
        resp_due = 0; m_busy = 0;
      end
      if (m_phase == 1) begin
        chk("rnd_bus_rd", bus_rd_o, (e_wr == 4'h0));
        chk("rnd_bus_wr", bus_wr_o, e_wr);
        chk("rnd_bus_addr", bus_addr_o, e_addr);
        if (e_wr != 4'h0) chk("rnd_bus_wdata", bus_data_wr_o, e_wdata);
      end else begin
        chk("rnd_bus_idle", {bus_rd_o, bus_wr_o}, 0);
      end

      bus_accept_i = 0; bus_ack_i = 0; bus_error_i = 0; bus_data_rd_i = $urandom;
      if (m_phase == 1) begin
        if ($urandom_range(2) != 0) begin
          bus_accept_i = 1; m_phase = 2; wait_left = $urandom_range(3);
        end
      end else if (m_phase == 2) begin
        if (wait_left == 0) begin
          bus_ack_i = 1; bus_error_i = ($urandom_range(4) == 0);
          resp_due = 1; r_owner = e_owner; r_err = bus_error_i; r_data = bus_data_rd_i;
          r_pc = e_addr; r_chk = (e_wr == 4'h0) || r_err;
          m_phase = 0;
        end else begin
          wait_left--;
        end
      end else if ($urandom_range(5) == 0) begin
        bus_ack_i = 1;
      end

      if (!f_pend && $urandom_range(2) == 0) begin
        f_pend = 1; tmp = $urandom; f_pc = tmp & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1; d_addr = $urandom; d_wdata = $urandom;
        case ($urandom_range(2))
          0:       begin d_rd = 1; d_wr = 4'h0; end
          1:       begin d_rd = 0; d_wr = 4'($urandom_range(15, 1)); end
          default: begin d_rd = 1; d_wr = 4'($urandom_range(15, 1)); end
        endcase
      end
      icache_rd_i = f_pend; icache_pc_i = f_pc;
      mem_d_rd_i = d_pend && d_rd; mem_d_wr_i = d_pend ? d_wr : 4'h0;
      mem_d_addr_i = d_addr; mem_d_data_wr_i = d_wdata;
      #1;

      g = 0;
      if (!m_busy) begin
        if (f_pend && d_pend) begin
`ifdef RISCV_ARB_RR_EN
          g = m_last_data ? 1 : 2;
`else
          g = 2;
`endif
        end else if (f_pend) g = 1;
        else if (d_pend) g = 2;
      end
      if (m_busy) chk("rnd_busy_acc", {icache_accept_o, mem_d_accept_o}, 0);
      else begin
        if (f_pend) chk("rnd_iacc", icache_accept_o, g == 1);
        if (d_pend) chk("rnd_dacc", mem_d_accept_o, g == 2);
      end
      if (g != 0) begin
        m_busy = 1; m_phase = 1; m_last_data = (g == 2); e_owner = (g == 2);
        if (g == 1) begin
          e_addr = f_pc; e_wr = 4'h0; e_wdata = '0; f_pend = 0;
        end else begin
          e_addr = d_addr; e_wr = d_wr; e_wdata = d_wdata; d_pend = 0;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
